// File: rtl/tmds_decoder_align.sv
// rtl/tmds_decoder_align.sv - TMDS channel symbol aligner and 10b-to-8b decoder
// Optional feature macro: TMDS_DEC_LOSS_CNT_EN (adds lock_loss_cnt_o)
module tmds_decoder_align #(
   parameter int LOCK_CNT = 8,
   parameter int TIMEOUT  = 2048
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [9:0] raw_i,
   output logic [7:0] data_o,
   output logic       c0_o,
   output logic       c1_o,
   output logic       de_o,
   output logic       valid_o,
   output logic       locked_o,
   output logic [3:0] offset_o
`ifdef TMDS_DEC_LOSS_CNT_EN
   ,
   output logic [7:0] lock_loss_cnt_o
`endif
);

   localparam int CW = $clog2(LOCK_CNT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LOCK = CW'(LOCK_CNT);
   localparam logic [TW-1:0] TMR_MAX  = TW'(TIMEOUT);

   typedef enum logic {SEARCH, LOCKED} state_t;

   state_t        state_q, state_d;
   logic [9:0]    prev_q;
   logic [3:0]    cand_q, cand_d;
   logic [3:0]    off_q, off_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [9:0]    word_q;
   logic          word_vld_q;
   logic [7:0]    data_q, data_d;
   logic          c0_q, c0_d, c1_q, c1_d, de_q, de_d, valid_q;

   logic [19:0]   window;
   logic [9:0]    words [10];
   logic [9:0]    tok_hit;
   logic          any_hit;
   logic [3:0]    first_hit;
   logic [7:0]    dec;

   function automatic logic is_token(input logic [9:0] w);
      return (w == 10'b1101010100) || (w == 10'b0010101011) ||
             (w == 10'b0101010100) || (w == 10'b1010101011);
   endfunction

   // Older word occupies the low half so bit 0 of the window is the earliest bit.
   assign window = {raw_i, prev_q};

   // Slice all ten candidate symbols and flag which ones are control tokens.
   always_comb begin
      for (int k = 0; k < 10; k++) begin
         words[k]   = window[k +: 10];
         tok_hit[k] = is_token(words[k]);
      end
   end

   // Lowest matching offset wins when several alignments look like tokens.
   always_comb begin
      any_hit   = 1'b0;
      first_hit = 4'd0;
      for (int k = 9; k >= 0; k--) begin
         if (tok_hit[k]) begin
            any_hit   = 1'b1;
            first_hit = 4'(k);
         end
      end
   end

   // Alignment FSM: count consecutive hits at one offset, then watch for token loss.
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      off_d   = off_q;
      cnt_d   = cnt_q;
      timer_d = timer_q;
      unique case (state_q)
         SEARCH: begin
            if (!any_hit) begin
               cnt_d = '0;
            end else if (first_hit == cand_q) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               cand_d = first_hit;
               cnt_d  = CW'(1);
            end
            if (cnt_d == CNT_LOCK) begin
               state_d = LOCKED;
               off_d   = cand_d;
               timer_d = '0;
            end
         end
         LOCKED: begin
            if (tok_hit[off_q]) begin
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
               if (timer_d == TMR_MAX) begin
                  state_d = SEARCH;
                  cnt_d   = '0;
               end
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   // Register FSM state, the word history and the aligned symbol for decode.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= SEARCH;
         prev_q     <= '0;
         cand_q     <= '0;
         off_q      <= '0;
         cnt_q      <= '0;
         timer_q    <= '0;
         word_q     <= '0;
         word_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_q     <= raw_i;
         cand_q     <= cand_d;
         off_q      <= off_d;
         cnt_q      <= cnt_d;
         timer_q    <= timer_d;
         word_q     <= words[off_d];
         word_vld_q <= (state_d == LOCKED);
      end
   end

   // Decode the aligned symbol: control token lookup or transition-minimised data.
   always_comb begin
      data_d = '0;
      c0_d   = 1'b0;
      c1_d   = 1'b0;
      de_d   = 1'b0;
      dec    = word_q[9] ? ~word_q[7:0] : word_q[7:0];
      if (word_vld_q) begin
         unique case (word_q)
            10'b1101010100: {c1_d, c0_d} = 2'b00;
            10'b0010101011: {c1_d, c0_d} = 2'b01;
            10'b0101010100: {c1_d, c0_d} = 2'b10;
            10'b1010101011: {c1_d, c0_d} = 2'b11;
            default: begin
               de_d      = 1'b1;
               data_d[0] = dec[0];
               for (int i = 1; i < 8; i++) begin
                  data_d[i] = word_q[8] ? (dec[i] ^ dec[i-1]) : ~(dec[i] ^ dec[i-1]);
               end
            end
         endcase
      end
   end

   // Output register stage for the decoded symbol.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q  <= '0;
         c0_q    <= 1'b0;
         c1_q    <= 1'b0;
         de_q    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         c0_q    <= c0_d;
         c1_q    <= c1_d;
         de_q    <= de_d;
         valid_q <= word_vld_q;
      end
   end

   assign data_o   = data_q;
   assign c0_o     = c0_q;
   assign c1_o     = c1_q;
   assign de_o     = de_q;
   assign valid_o  = valid_q;
   assign locked_o = (state_q == LOCKED);
   assign offset_o = (state_q == LOCKED) ? off_q : cand_q;

`ifdef TMDS_DEC_LOSS_CNT_EN
   logic [7:0] loss_q;

   // Count lock drops caused by token timeout, saturating at 255.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         loss_q <= '0;
      end else if ((state_q == LOCKED) && (state_d == SEARCH) && (loss_q != 8'hff)) begin
         loss_q <= loss_q + 8'd1;
      end
   end

   assign lock_loss_cnt_o = loss_q;
`endif

endmodule

// File: tb/tb_tmds_decoder_align.sv
// tb/tb_tmds_decoder_align.sv - randomized scoreboard bench for tmds_decoder_align
`timescale 1ns/1ps
module tb_tmds_decoder_align;

   localparam int LOCK_CNT = 8;
   localparam int TIMEOUT  = 64;

   logic       clk    = 1'b0;
   logic       rst_ni = 1'b1;
   logic [9:0] raw_i  = '0;
   logic [7:0] data_o;
   logic       c0_o, c1_o, de_o, valid_o, locked_o;
   logic [3:0] offset_o;
`ifdef TMDS_DEC_LOSS_CNT_EN
   logic [7:0] lock_loss_cnt_o;
`endif

   tmds_decoder_align #(.LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_ni),
      .raw_i    (raw_i),
      .data_o   (data_o),
      .c0_o     (c0_o),
      .c1_o     (c1_o),
      .de_o     (de_o),
      .valid_o  (valid_o),
      .locked_o (locked_o),
      .offset_o (offset_o)
`ifdef TMDS_DEC_LOSS_CNT_EN
      ,
      .lock_loss_cnt_o (lock_loss_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int         edge_n;
      logic       de;
      logic [7:0] data;
      logic       c1;
      logic       c0;
   } exp_t;

   exp_t       sbq[$];
   exp_t       mon_e;
   bit         bits_q[$];
   logic [7:0] lut [1024];
   logic [9:0] toks [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

   int n_vec = 0;
   int n_err = 0;
   int edge_cnt = 0;

   bit         m_locked;
   int         m_cand, m_cnt, m_off, m_timer, m_loss;
   logic [9:0] m_prev;

   always @(posedge clk) edge_cnt++;

   function automatic int tok_idx(input logic [9:0] w);
      for (int i = 0; i < 4; i++) if (w == toks[i]) return i;
      return -1;
   endfunction

   // Reference TMDS data encoder; decoding is checked as its inverse.
   function automatic logic [9:0] encode(input logic [7:0] d, input logic q8, input logic q9);
      logic [7:0] qm;
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = q8 ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
      return {q9, q8, (q9 ? ~qm : qm)};
   endfunction

   function automatic logic [9:0] rand_data();
      logic [9:0] s;
      do s = encode(8'($urandom), 1'($urandom), 1'($urandom)); while (tok_idx(s) >= 0);
      return s;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_locked = 1'b0; m_cand = 0; m_cnt = 0; m_off = 0; m_timer = 0; m_loss = 0; m_prev = '0;
   endtask

   task automatic model_step(input logic [9:0] w);
      logic [19:0] win;
      logic [9:0]  q;
      int          m, ti;
      exp_t        e;
      win = {w, m_prev};
      m = -1;
      for (int k = 0; k < 10; k++) if (m < 0 && tok_idx(10'(win >> k)) >= 0) m = k;
      if (!m_locked) begin
         if (m < 0) m_cnt = 0;
         else if (m == m_cand) m_cnt++;
         else begin m_cand = m; m_cnt = 1; end
         if (m_cnt == LOCK_CNT) begin m_locked = 1'b1; m_off = m_cand; m_timer = 0; end
      end else begin
         q = 10'(win >> m_off);
         if (tok_idx(q) >= 0) m_timer = 0;
         else begin
            m_timer++;
            if (m_timer == TIMEOUT) begin
               m_locked = 1'b0; m_cnt = 0;
               if (m_loss < 255) m_loss++;
            end
         end
      end
      if (m_locked) begin
         q  = 10'(win >> m_off);
         ti = tok_idx(q);
         e.edge_n = edge_cnt + 2;
         e.de     = (ti < 0);
         e.data   = (ti < 0) ? lut[q] : 8'h00;
         {e.c1, e.c0} = (ti < 0) ? 2'b00 : 2'(ti);
         sbq.push_back(e);
      end
      m_prev = w;
   endtask

   task automatic push_sym(input logic [9:0] s);
      for (int i = 0; i < 10; i++) bits_q.push_back(s[i]);
   endtask

   task automatic push_bits(input int n, input bit rnd);
      for (int i = 0; i < n; i++) bits_q.push_back(rnd ? 1'($urandom) : 1'b0);
   endtask

   task automatic drive_word();
      logic [9:0] w;
      for (int i = 0; i < 10; i++) w[i] = bits_q.pop_front();
      raw_i = w;
      model_step(w);
      @(posedge clk);
      #1;
      chk("locked", int'(locked_o), int'(m_locked));
      chk("offset", int'(offset_o), m_locked ? m_off : m_cand);
   endtask

   task automatic flush();
      while (bits_q.size() >= 10) drive_word();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_locked"}, int'(locked_o), 0);
      chk({tag, "_valid"},  int'(valid_o), 0);
      chk({tag, "_offset"}, int'(offset_o), 0);
      chk({tag, "_out"},    int'({data_o, de_o, c1_o, c0_o}), 0);
   endtask

   task automatic timeout_round();
      repeat (9) push_sym(toks[0]);
      repeat (TIMEOUT) push_sym(rand_data());
      flush();
   endtask

   // Scoreboard monitor: every decoded symbol must match the next expectation in order and time.
   always @(negedge clk) begin
      if (rst_ni) begin
         if (valid_o) begin
            n_vec++;
            if (sbq.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_valid: got de=%0b data=%02h c=%0b%0b, want none", de_o, data_o, c1_o, c0_o);
            end else begin
               mon_e = sbq.pop_front();
               if (mon_e.edge_n != edge_cnt || de_o != mon_e.de ||
                   (mon_e.de && data_o != mon_e.data) ||
                   (!mon_e.de && {c1_o, c0_o} != {mon_e.c1, mon_e.c0})) begin
                  n_err++;
                  $display("FAIL decode: got edge=%0d de=%0b data=%02h c=%0b%0b, want edge=%0d de=%0b data=%02h c=%0b%0b",
                           edge_cnt, de_o, data_o, c1_o, c0_o,
                           mon_e.edge_n, mon_e.de, mon_e.data, mon_e.c1, mon_e.c0);
               end
            end
         end else begin
            n_vec++;
            if ({data_o, de_o, c1_o, c0_o} != '0) begin
               n_err++;
               $display("FAIL idle_outputs: got %03h, want 0", {data_o, de_o, c1_o, c0_o});
            end
            if (sbq.size() > 0 && sbq[0].edge_n <= edge_cnt) begin
               n_err++;
               mon_e = sbq.pop_front();
               $display("FAIL missing_valid: got valid=0, want de=%0b data=%02h at edge %0d",
                        mon_e.de, mon_e.data, mon_e.edge_n);
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p, n;
      logic [9:0] tk;

      for (int q9 = 0; q9 < 2; q9++)
         for (int q8 = 0; q8 < 2; q8++)
            for (int d = 0; d < 256; d++)
               lut[encode(8'(d), 1'(q8), 1'(q9))] = 8'(d);

      // Asynchronous reset before any clock edge.
      #1 rst_ni = 1'b0;
      #1 check_all_zero("reset");
      model_reset();
      @(negedge clk) rst_ni = 1'b1;

      // Directed lock at offset 3 followed by the two directed decode symbols.
      push_bits(3, 1'b0);
      repeat (LOCK_CNT) push_sym(toks[0]);
      flush();
      chk("lock_before_8th", int'(locked_o), 0);
      push_sym(10'b0100000000);
      push_sym(10'b1010101011);
      repeat (3) push_sym(toks[3]);
      drive_word();
      chk("lock_on_8th", int'(locked_o), 1);
      chk("lock_offset", int'(offset_o), 3);
      flush();

      // Reset while locked drops everything immediately.
      #2 rst_ni = 1'b0;
      #1 check_all_zero("midreset");
      model_reset();
      sbq.delete();
      bits_q.delete();
      @(negedge clk) rst_ni = 1'b1;

      // Interrupted search, lock, then a timeout run at a random phase.
      p  = $urandom_range(0, 9);
      tk = toks[$urandom_range(0, 3)];
      push_bits(p, 1'b1);
      repeat (5) push_sym(tk);
      push_sym(rand_data());
      repeat (LOCK_CNT) push_sym(tk);
      repeat (TIMEOUT + 1) push_sym(rand_data());
      flush();
      chk("timeout_unlocked", int'(locked_o), 0);

      // Random bit slips, token bursts and data bursts.
      for (int r = 0; r < 40; r++) begin
         push_bits($urandom_range(0, 9), 1'b1);
         tk = toks[$urandom_range(0, 3)];
         n = $urandom_range(0, 12);
         repeat (n) push_sym(tk);
         n = $urandom_range(0, 80);
         repeat (n) begin
            if ($urandom_range(0, 7) == 0) push_sym(toks[$urandom_range(0, 3)]);
            else push_sym(rand_data());
         end
         flush();
      end

      // Repeated lock/timeout cycles from a clean reset.
      #2 rst_ni = 1'b0;
      #1 model_reset();
      sbq.delete();
      bits_q.delete();
      @(negedge clk) rst_ni = 1'b1;
      push_bits(5, 1'b0);
      repeat (2) timeout_round();
      push_sym(toks[0]);
      flush();
      chk("two_timeouts_model", m_loss, 2);
`ifdef TMDS_DEC_LOSS_CNT_EN
      chk("loss_cnt_2", int'(lock_loss_cnt_o), 2);
      repeat (298) timeout_round();
      push_sym(toks[0]);
      flush();
      chk("loss_cnt_sat", int'(lock_loss_cnt_o), 255);
`endif

      // Drain the decode pipeline and confirm nothing was left unmatched.
      repeat (2) push_sym(rand_data());
      flush();
      repeat (2) @(negedge clk);
      #1 chk("scoreboard_drained", sbq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tmds_decoder_align.md
# tmds_decoder_align

Receive-side counterpart of the DVI TMDS transmit path. Takes unaligned 10-bit words from a 1:10 deserializer on one TMDS channel, finds the symbol boundary using TMDS control tokens, and locks to it. Once locked, it decodes each 10-bit symbol back to 8-bit pixel data, or to the C0/C1 control pair with DE.

## Interface
Parameters:
- LOCK_CNT, 8: consecutive control-token cycles at one offset required to lock.
- TIMEOUT, 2048: cycles without a control token at the locked offset before lock is dropped.

Ports:
- clk_i  in  1  pixel clock, sole clock.
- rst_ni  in  1  asynchronous, active-low reset.
- raw_i  in  10  deserialized word. Bit 0 is the earliest bit on the wire. Boundary phase is arbitrary.
- data_o  out  8  decoded pixel byte. Meaningful when de_o=1.
- c0_o  out  1  decoded C0. Meaningful when de_o=0 and valid_o=1.
- c1_o  out  1  decoded C1. Meaningful when de_o=0 and valid_o=1.
- de_o  out  1  data enable: 1 for a data symbol, 0 for a control token.
- valid_o  out  1  outputs carry a decoded symbol from the locked stream.
- locked_o  out  1  alignment FSM is in LOCKED.
- offset_o  out  4  current or candidate bit offset, 0..9.

## Operation
- Window: prev_r holds the previous raw_i. The 20-bit window is {raw_i, prev_r}. The word at offset k is window[k+9:k], for k = 0..9.
- Control tokens and their (C1,C0) values:
  - 10'b1101010100 → 00
  - 10'b0010101011 → 01
  - 10'b0101010100 → 10
  - 10'b1010101011 → 11
- All 10 offsets are compared against the 4 tokens in parallel every cycle.
- FSM states: SEARCH and LOCKED. Reset state is SEARCH.
- SEARCH:
  - Let m be the lowest offset with a token match.
  - If there is no match, cnt ← 0.
  - Else if m == cand, cnt ← cnt+1.
  - Else cand ← m and cnt ← 1.
  - When the updated cnt equals LOCK_CNT, go to LOCKED with off ← cand and timer ← 0.
- LOCKED:
  - Offset is frozen.
  - Token at off: timer ← 0.
  - Otherwise timer ← timer+1. When timer reaches TIMEOUT, go to SEARCH with cnt ← 0.
  - Tokens at other offsets are ignored.
- Decode applies only to the word q at off, and only in LOCKED.
  - Token: de_o=0, and c1_o/c0_o come from the token table.
  - Otherwise de_o=1. Let d = q[9] ? ~q[7:0] : q[7:0].
  - Then data_o[0] = d[0].
  - For i = 1..7: data_o[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- When not LOCKED: valid_o=0, de_o=0, data_o=0, c0_o=0, c1_o=0.
- offset_o shows cand in SEARCH and off in LOCKED.
- Counter widths: cnt is $clog2(LOCK_CNT+1) bits; timer is $clog2(TIMEOUT+1) bits. Neither wraps.

## Timing
- Reset values: all outputs 0; state SEARCH; cand=0; cnt=0; timer=0; prev_r=0.
- Reset asserts asynchronously and releases on the first clk_i edge after rst_ni goes high. Reset mid-lock drops lock immediately.
- Pipeline:
  - Edge n: raw_i sampled; the FSM updates; the aligned word is registered.
  - Edge n+1: decoded outputs are registered.
  - Decode latency is 2 edges from the edge that samples the word completing the symbol.
- locked_o rises on the edge where cnt reaches LOCK_CNT.
- The first valid_o=1 appears one edge after locked_o rises.
- locked_o falls on the edge where timer reaches TIMEOUT. valid_o falls one edge later.
- Several offsets matching in one cycle (shifted alternating tokens): the lowest offset wins.
- LOCK_CNT=1 locks on the first match.

## Configuration
- TMDS_DEC_LOSS_CNT_EN defined:
  - Adds output lock_loss_cnt_o, out, 8 bits: saturating count of LOCKED→SEARCH transitions caused by timeout.
  - Reset value 0. Holds at 255.
  - A reset during LOCKED is not counted.
- Undefined: the port and its logic are absent.

## Test plan
- Reset: rst_ni=0 mid-stream → all outputs 0 asynchronously, before any clk_i edge; state SEARCH.
- Lock: stream of 10'b1101010100 shifted by 3 bits, 8 words (LOCK_CNT=8) → locked_o=1 on the 8th word's edge; offset_o=3.
- Decode, offset 3:
  - q=10'b0100000000 → data_o=8'h00, de_o=1.
  - q=10'b1010101011 → de_o=0, c1_o=1, c0_o=1.
  - Both appear 2 edges after sampling, with valid_o=1.
- Interrupted search: 5 tokens, then 1 random data word, then 8 tokens → locked_o rises only on the 8th token of the second run.
- Timeout (TIMEOUT=64): after lock, 64 consecutive data words → locked_o falls on the 64th word; valid_o=0 on the next edge.
- TMDS_DEC_LOSS_CNT_EN: force 2 timeouts → lock_loss_cnt_o=2. Force 300 timeouts → lock_loss_cnt_o=255.
